mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-port word memory (combinational read, write on clock edge, 256 x 32) between the instruction-fetch requester and the load/store requester of the CPU. Requests use a hold-until-ack handshake. The arbiter registers the grant, drives the memory for exactly one cycle, captures the read data and returns it with a one-cycle acknowledge. Priority is data-first, with a starvation limit that guarantees fetch forward progress.

---
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 32-bit word memory between an
// instruction-fetch requester (f_*) and a load/store requester (d_*).
// Each request is latched in IDLE, performs one memory cycle in ACCESS and
// is answered with a one-cycle ack in RESP. Data requests win contention
// unless fetch has lost STARVE_MAX consecutive arbitrations.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_req/f_addr                  fetch request, byte address
//   f_ack/f_rdata/f_err           fetch completion, read data, address error
//   d_req/d_we/d_addr/d_wdata     load/store request
//   d_ack/d_rdata/d_err           load/store completion, read data, error
//   m_addr/m_din/m_we/m_re        memory word index, write data, enables
//   m_dout                        memory read data (combinational)
module mem_arbiter #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic        m_we,
  output logic        m_re,
  input  logic [31:0] m_dout
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            sel_f_q, sel_f_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_din_q, m_din_d;
  logic            f_ack_q, f_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            f_err_q, f_err_d;
  logic            d_err_q, d_err_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;

  logic            win_f;
  logic [AW-1:0]   win_addr;
  logic            win_err;
  logic [DW-1:0]   resp;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      sel_f_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      m_addr_q  <= '0;
      m_din_q   <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      sel_f_q   <= sel_f_d;
      we_q      <= we_d;
      err_q     <= err_d;
      m_addr_q  <= m_addr_d;
      m_din_q   <= m_din_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_err_q   <= f_err_d;
      d_err_q   <= d_err_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (f_req || d_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Arbitration, request latch and response capture
  always_comb begin
    starve_d  = starve_q;
    sel_f_d   = sel_f_q;
    we_d      = we_q;
    err_d     = err_q;
    m_addr_d  = m_addr_q;
    m_din_d   = m_din_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_err_d   = f_err_q;
    d_err_d   = d_err_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;

    // Fetch wins when alone, or when data has starved it long enough
    win_f    = f_req && (!d_req || (starve_q == STARVE_LIM));
    win_addr = win_f ? f_addr : d_addr;
    win_err  = (win_addr[1:0] != 2'b00) ||
               ({2'b00, win_addr[AW-1:2]} >= AW'(DEPTH));
    resp     = (err_q || we_q) ? '0 : m_dout;

    case (state_q)
      S_IDLE: begin
        // Counts data wins over a waiting fetch; any other outcome clears it
        if (!f_req || win_f) begin
          starve_d = '0;
        end else if (starve_q < STARVE_LIM) begin
          starve_d = starve_q + CW'(1);
        end
        if (f_req || d_req) begin
          sel_f_d = win_f;
          we_d    = !win_f && d_we;
          err_d   = win_err;
          // Memory-side address/data only move for accesses that reach memory
          if (!win_err) begin
            m_addr_d = {2'b00, win_addr[AW-1:2]};
            if (!win_f && d_we) m_din_d = d_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (sel_f_q) begin
          f_ack_d   = 1'b1;
          f_err_d   = err_q;
          f_rdata_d = resp;
        end else begin
          d_ack_d   = 1'b1;
          d_err_d   = err_q;
          d_rdata_d = resp;
        end
      end
      default: ;
    endcase
  end

  // Memory strobes; a store coinciding with reset is suppressed
  always_comb begin
    m_re = 1'b0;
    m_we = 1'b0;
    if ((state_q == S_ACCESS) && !err_q) begin
      m_re = !we_q;
      m_we = we_q && !rst;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_din   = m_din_q;
  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign f_err   = f_err_q;
  assign d_err   = d_err_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for
// mem_arbiter, checked against a transaction-level reference model
// (reference memory, per-requester pending state and the priority rule).
module tb_mem_arbiter;

  localparam int unsigned DEPTH      = 256;
  localparam int unsigned STARVE_MAX = 3;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic        m_we;
  logic        m_re;
  logic [31:0] m_dout;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  mem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_re(m_re), .m_dout(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side single-port memory: combinational read, write on rising edge
  assign m_dout = mem[m_addr[7:0]];
  always @(posedge clk) if (m_we) mem[m_addr[7:0]] = m_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic we);
    if (addr_bad(a) || we) return 32'h0;
    return ref_mem[a[9:2]];
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    if (r == 1) return 32'h400 + (32'($urandom_range(0, 63)) << 2);
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // One isolated request from an idle arbiter, with full cycle-level checks
  task automatic single_op(input logic is_f, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
    int   lat;
    int   n_we;
    int   n_re;
    logic got_ack;
    logic e;
    logic [31:0] exp_d;
    e     = addr_bad(addr);
    exp_d = exp_rd(addr, we);
    if (is_f) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    lat = 0; n_we = 0; n_re = 0; got_ack = 1'b0;
    while (!got_ack && lat < 20) begin
      tick();
      lat++;
      if (m_re || m_we) check({tag, "_maddr"}, m_addr, addr >> 2);
      if (m_we) begin
        n_we++;
        check({tag, "_mdin"}, m_din, wdata);
      end
      if (m_re) n_re++;
      got_ack = is_f ? f_ack : d_ack;
      if (is_f) check({tag, "_other_ack"}, d_ack, 0);
      else      check({tag, "_other_ack"}, f_ack, 0);
    end
    check({tag, "_lat"}, lat, 2);
    if (got_ack) begin
      check({tag, "_rdata"}, is_f ? f_rdata : d_rdata, exp_d);
      check({tag, "_err"}, is_f ? f_err : d_err, e);
    end
    check({tag, "_nre"}, n_re, (!e && !we) ? 1 : 0);
    check({tag, "_nwe"}, n_we, (!e && we) ? 1 : 0);
    if (we && !e) ref_mem[addr[9:2]] = wdata;
    f_req = 1'b0;
    d_req = 1'b0;
    tick();
    check({tag, "_ack_drop"}, {31'd0, f_ack | d_ack}, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int   last, nacks, dwins, n, last_f, gap_f;
    logic exp_f;
    logic f_pend, d_pend, fa, da;
    int   f_raise, d_raise, streak;

    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;

    tick(); tick();
    check("rst_f_ack", f_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_f_err", f_err, 0);
    check("rst_d_err", d_err, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_re", m_re, 0);
    check("rst_f_rdata", f_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_din", m_din, 0);
    rst = 1'b0;
    tick();

    single_op(1'b0, 1'b0, 32'h14, 32'h0, "load5");
    single_op(1'b0, 1'b1, 32'h8, 32'h00A00093, "store2");
    single_op(1'b1, 1'b0, 32'h8, 32'h0, "fetch2");
    single_op(1'b0, 1'b0, 32'h2, 32'h0, "err_load");
    single_op(1'b1, 1'b0, 32'h400, 32'h0, "err_fetch");
    single_op(1'b0, 1'b1, 32'h3FC, 32'h13579BDF, "store_top");
    single_op(1'b0, 1'b0, 32'h3FC, 32'h0, "load_top");

    // Lone fetch: back-to-back acks every 3 cycles
    f_req = 1'b1; f_addr = 32'h8;
    last = -1; nacks = 0; n = 0;
    while (nacks < 4 && n < 40) begin
      tick(); n++;
      check("lone_dack", d_ack, 0);
      if (f_ack) begin
        nacks++;
        check("lone_rdata", f_rdata, ref_mem[2]);
        if (last >= 0) check("lone_gap", cyc - last, 3);
        last = cyc;
      end
    end
    check("lone_cnt", nacks, 4);

    // Both held: data wins STARVE_MAX times, then fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    dwins = 0; n = 0; nacks = 0; last_f = -1; gap_f = 0;
    while (nacks < 8 && n < 80) begin
      tick(); n++;
      check("cont_both", {31'd0, f_ack & d_ack}, 0);
      if (f_ack || d_ack) begin
        exp_f = (dwins == STARVE_MAX);
        dwins = exp_f ? 0 : dwins + 1;
        check($sformatf("cont_grant%0d", nacks), f_ack, exp_f);
        check("cont_gap", cyc - last, 3);
        if (f_ack) begin
          check("cont_f_rdata", f_rdata, ref_mem[2]);
          if (last_f >= 0) check("cont_f_period", cyc - last_f, 4 * (STARVE_MAX + 1) - 4 + 4 * 0 + (3 * (STARVE_MAX + 1) - 4 * STARVE_MAX));
          last_f = cyc;
        end else begin
          check("cont_d_rdata", d_rdata, ref_mem[5]);
        end
        last = cyc;
        nacks++;
      end
    end
    check("cont_cnt", nacks, 8);
    f_req = 1'b0; d_req = 1'b0;
    tick();
    check("cont_drop", {31'd0, f_ack | d_ack}, 0);
    tick();

    // Reset during the ACCESS cycle of a store to word 3
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'h5555AAAA;
    tick();
    check("rst_store_mwe", m_we, 1);
    rst = 1'b1;
    #1;
    check("rst_store_mwe_forced", m_we, 0);
    d_req = 1'b0;
    tick();
    check("rsts_d_ack", d_ack, 0);
    check("rsts_f_rdata", f_rdata, 0);
    check("rsts_d_rdata", d_rdata, 0);
    check("rsts_m_addr", m_addr, 0);
    check("rsts_m_din", m_din, 0);
    check("rsts_m_re", m_re, 0);
    rst = 1'b0;
    check("rsts_word3", mem[3], ref_mem[3]);
    tick();
    single_op(1'b0, 1'b0, 32'hC, 32'h0, "post_rst_load");

    // Randomized traffic against the transaction-level model
    f_pend = 1'b0; d_pend = 1'b0; streak = 0;
    f_raise = 0; d_raise = 0;
    for (int it = 0; it < 900; it++) begin
      tick();
      fa = f_ack; da = d_ack;
      if (fa && da) check("rnd_both_ack", 1, 0);
      if (m_we) begin
        if (d_pend && d_we && !addr_bad(d_addr)) begin
          check("rnd_mwe_addr", m_addr, d_addr >> 2);
          check("rnd_mwe_din", m_din, d_wdata);
        end else begin
          check("rnd_mwe_stray", 1, 0);
        end
      end
      if (fa) begin
        if (!f_pend) check("rnd_f_stray", 1, 0);
        else begin
          if (d_pend && d_raise <= cyc - 2) check("rnd_f_prio", streak, STARVE_MAX);
          streak = 0;
          check("rnd_f_err", f_err, addr_bad(f_addr));
          check("rnd_f_rdata", f_rdata, exp_rd(f_addr, 1'b0));
          f_pend = 1'b0;
        end
      end
      if (da) begin
        if (!d_pend) check("rnd_d_stray", 1, 0);
        else begin
          if (f_pend && f_raise <= cyc - 2) begin
            check("rnd_d_starve", streak < STARVE_MAX, 1);
            streak++;
          end else begin
            streak = 0;
          end
          check("rnd_d_err", d_err, addr_bad(d_addr));
          check("rnd_d_rdata", d_rdata, exp_rd(d_addr, d_we));
          if (d_we && !addr_bad(d_addr)) ref_mem[d_addr[9:2]] = d_wdata;
          d_pend = 1'b0;
        end
      end
      if (f_pend && (cyc - f_raise) > 15) begin
        check("rnd_f_timeout", cyc - f_raise, 15);
        f_pend = 1'b0;
      end
      if (d_pend && (cyc - d_raise) > 15) begin
        check("rnd_d_timeout", cyc - d_raise, 15);
        d_pend = 1'b0;
      end
      if (!f_pend) begin
        if (it < 850 && $urandom_range(0, 2) != 0) begin
          f_req = 1'b1; f_addr = rand_addr();
          f_pend = 1'b1; f_raise = cyc;
        end else begin
          f_req = 1'b0;
        end
      end
      if (!d_pend) begin
        if (it < 850 && $urandom_range(0, 2) != 0) begin
          d_req = 1'b1; d_addr = rand_addr();
          d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
          d_pend = 1'b1; d_raise = cyc;
        end else begin
          d_req = 1'b0;
        end
      end
    end
    check("rnd_drained", {30'd0, f_pend, d_pend}, 0);
    for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
